// File: rtl/opamp_cmp_monitor_if.sv
// Signal bundle between the comparator monitor and its host.
// The master side drives the analog inputs and configuration strobes;
// the slave side is the monitor, which returns debounced state, flags,
// edge counters and the interrupt request.
interface opamp_cmp_monitor_if #(
  parameter int CHANNELS = 4,
  parameter int DEB_W    = 8,
  parameter int CNT_W    = 16
);
  logic [CHANNELS-1:0]       cmp_raw_i;
  logic                      supply_ok_i;
  logic [CHANNELS-1:0]       cfg_en_i;
  logic [DEB_W-1:0]          cfg_deb_i;
  logic [CHANNELS-1:0]       irq_mask_i;
  logic [CHANNELS-1:0]       irq_ack_i;
  logic [CHANNELS-1:0]       cnt_clr_i;
  logic [CHANNELS-1:0]       cmp_state_o;
  logic [CHANNELS-1:0]       flag_o;
  logic [CHANNELS*CNT_W-1:0] cnt_o;
  logic                      irq_o;

  modport master (
    output cmp_raw_i, supply_ok_i, cfg_en_i, cfg_deb_i,
           irq_mask_i, irq_ack_i, cnt_clr_i,
    input  cmp_state_o, flag_o, cnt_o, irq_o
  );

  modport slave (
    input  cmp_raw_i, supply_ok_i, cfg_en_i, cfg_deb_i,
           irq_mask_i, irq_ack_i, cnt_clr_i,
    output cmp_state_o, flag_o, cnt_o, irq_o
  );
endinterface

// File: rtl/opamp_cmp_monitor.sv
// Multi-channel opamp/comparator monitor.
// Each raw comparator output is synchronised, debounced against a
// programmable threshold and gated by the analog supply-good indication.
// Debounced rising edges bump a saturating counter and set a sticky flag;
// masked flags are OR-ed into a registered interrupt.
module opamp_cmp_monitor #(
  parameter int CHANNELS = 4,
  parameter int DEB_W    = 8,
  parameter int CNT_W    = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  opamp_cmp_monitor_if.slave    bus
);

  // Two-flop synchronisers for the raw comparators and the supply-good line.
  logic [CHANNELS-1:0] raw_meta_reg;
  logic [CHANNELS-1:0] raw_sync_reg;
  logic                sok_meta_reg;
  logic                sok_sync_reg;
  logic                sok_hold_reg;

  // Supply qualification is fast-off / slow-on: a low seen on the first
  // synchroniser stage forces the channels immediately, while a restore
  // has to persist through one extra stage before debouncing resumes.
  logic supply_good;
  assign supply_good = sok_meta_reg & sok_sync_reg & sok_hold_reg;

  // A threshold of 0 behaves like 1; toggle once the counter reaches Deff-1.
  logic [DEB_W-1:0] deb_eff;
  logic [DEB_W-1:0] deb_last;
  assign deb_eff  = (bus.cfg_deb_i == '0) ? DEB_W'(1) : bus.cfg_deb_i;
  assign deb_last = deb_eff - DEB_W'(1);

  logic [CHANNELS-1:0] state_vec;
  logic [CHANNELS-1:0] flag_vec;
  logic                irq_reg;

  // Synchroniser pipeline for asynchronous inputs.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      raw_meta_reg <= '0;
      raw_sync_reg <= '0;
      sok_meta_reg <= 1'b0;
      sok_sync_reg <= 1'b0;
      sok_hold_reg <= 1'b0;
    end else begin
      raw_meta_reg <= bus.cmp_raw_i;
      raw_sync_reg <= raw_meta_reg;
      sok_meta_reg <= bus.supply_ok_i;
      sok_sync_reg <= sok_meta_reg;
      sok_hold_reg <= sok_sync_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DEB_W-1:0] deb_cnt_reg;
      logic             state_reg;
      logic             flag_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             forced;
      logic             mismatch;
      logic             toggle;
      logic             rise;

      assign forced   = !supply_good || !bus.cfg_en_i[gi];
      assign mismatch = raw_sync_reg[gi] != state_reg;
      // The >= comparison lets a lowered threshold fire on the next mismatch.
      assign toggle   = !forced && mismatch && (deb_cnt_reg >= deb_last);
      assign rise     = toggle && !state_reg;

      // Debounce: count consecutive mismatches, flip state at threshold.
      always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
          deb_cnt_reg <= '0;
          state_reg   <= 1'b0;
        end else if (forced) begin
          deb_cnt_reg <= '0;
          state_reg   <= 1'b0;
        end else if (!mismatch) begin
          deb_cnt_reg <= '0;
        end else if (toggle) begin
          deb_cnt_reg <= '0;
          state_reg   <= !state_reg;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
        end
      end

      // Saturating rising-edge counter; a clear coinciding with an edge yields 1.
      always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
          cnt_reg <= '0;
        end else if (bus.cnt_clr_i[gi]) begin
          cnt_reg <= CNT_W'(rise);
        end else if (rise && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      // Sticky flag; a new edge wins over a simultaneous acknowledge.
      always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
          flag_reg <= 1'b0;
        end else if (rise) begin
          flag_reg <= 1'b1;
        end else if (bus.irq_ack_i[gi]) begin
          flag_reg <= 1'b0;
        end
      end

      assign state_vec[gi]                   = state_reg;
      assign flag_vec[gi]                    = flag_reg;
      assign bus.cnt_o[gi*CNT_W +: CNT_W]    = cnt_reg;
    end
  endgenerate

  // Interrupt is the registered OR of masked flags, one cycle behind them.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |(flag_vec & bus.irq_mask_i);
    end
  end

  assign bus.cmp_state_o = state_vec;
  assign bus.flag_o      = flag_vec;
  assign bus.irq_o       = irq_reg;

endmodule
